// File: rtl/lake_mem_pkg.sv
// Shared memory-port definitions: access formats,
// format size helper, response state encoding.
package lake_mem_pkg;

  localparam logic [2:0] FMT_B  = 3'b000;
  localparam logic [2:0] FMT_H  = 3'b001;
  localparam logic [2:0] FMT_W  = 3'b010;
  localparam logic [2:0] FMT_BU = 3'b100;
  localparam logic [2:0] FMT_HU = 3'b101;

  // Wide enough for any starvation limit up to 15
  localparam int AGE_W = 4;

  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_F,
    RSP_D
  } rsp_state_t;

  function automatic logic [2:0] fmt_bytes(
    input logic [2:0] fmt
  );
    case (fmt)
      FMT_B, FMT_BU: fmt_bytes = 3'd1;
      FMT_H, FMT_HU: fmt_bytes = 3'd2;
      default:       fmt_bytes = 3'd4;
    endcase
  endfunction

  function automatic logic fmt_legal(
    input logic [2:0] fmt
  );
    case (fmt)
      FMT_B, FMT_H, FMT_W,
      FMT_BU, FMT_HU: fmt_legal = 1'b1;
      default:        fmt_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle for the fetch port (f), data port (d) and
// memory side (m); i_/o_ prefixes are as seen by the arbiter.
// Modports: master = core side (drives f/d requests),
// slave = arbiter, mem = memory model/macro.
interface mem_port_arbiter_if;

  logic        i_f_req;
  logic [31:0] i_f_addr;
  logic        o_f_gnt;
  logic        o_f_rvalid;
  logic [31:0] o_f_inst;
  logic        o_f_err;

  logic        i_d_req;
  logic        i_d_we;
  logic [31:0] i_d_addr;
  logic [31:0] i_d_w_data;
  logic [2:0]  i_d_fmt;
  logic        o_d_gnt;
  logic        o_d_rvalid;
  logic [31:0] o_d_r_data;
  logic        o_d_err;

  logic [31:0] o_m_addr;
  logic [31:0] o_m_w_data;
  logic [2:0]  o_m_fmt;
  logic        o_m_r_en;
  logic        o_m_w_en;
  logic [31:0] i_m_r_data;

  modport master (
    output i_f_req, i_f_addr,
    input  o_f_gnt, o_f_rvalid,
    input  o_f_inst, o_f_err,
    output i_d_req, i_d_we, i_d_addr,
    output i_d_w_data, i_d_fmt,
    input  o_d_gnt, o_d_rvalid,
    input  o_d_r_data, o_d_err
  );

  modport slave (
    input  i_f_req, i_f_addr,
    output o_f_gnt, o_f_rvalid,
    output o_f_inst, o_f_err,
    input  i_d_req, i_d_we, i_d_addr,
    input  i_d_w_data, i_d_fmt,
    output o_d_gnt, o_d_rvalid,
    output o_d_r_data, o_d_err,
    output o_m_addr, o_m_w_data, o_m_fmt,
    output o_m_r_en, o_m_w_en,
    input  i_m_r_data
  );

  modport mem (
    input  o_m_addr, o_m_w_data, o_m_fmt,
    input  o_m_r_en, o_m_w_en,
    output i_m_r_data
  );

endinterface

// File: rtl/mem_arb_age_ctr.sv
// Saturating count of consecutive cycles fetch was denied.
// Ports: clk_i, rst_i (async high), inc_i, clr_i, sat_o.
module mem_arb_age_ctr
  import lake_mem_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [AGE_W-1:0] LIM = AGE_W'(LIMIT);

  logic [AGE_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (inc_i && cnt_q != LIM)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sat_o = (cnt_q == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-port unified memory.
// Ports: i_clk, i_rst (async high), bus (slave modport:
// f/d request+response ports, m_* memory side).
// Build option MEM_ARB_ROUND_ROBIN_EN: alternate grants
// under contention instead of D-priority + starvation guard.
module mem_port_arbiter
  import lake_mem_pkg::*;
#(
  parameter int MEM_SIZE     = 1024,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [32:0] MEM_TOP = 33'(MEM_SIZE);

  logic f_req, d_req;
  logic f_win, f_gnt, d_gnt;

  assign f_req = bus.i_f_req;
  assign d_req = bus.i_d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic pref_f_q, pref_f_d;

  assign f_win = f_req && (!d_req || pref_f_q);

  // Pointer only moves on contention
  always_comb begin
    pref_f_d = pref_f_q;
    if (f_req && d_req)
      pref_f_d = !pref_f_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) pref_f_q <= 1'b0;
    else       pref_f_q <= pref_f_d;
  end
`else
  logic age_sat;

  mem_arb_age_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_age (
    .clk_i (i_clk),
    .rst_i (i_rst),
    .inc_i (f_req && !f_gnt),
    .clr_i (!f_req || f_gnt),
    .sat_o (age_sat)
  );

  assign f_win = f_req && (!d_req || age_sat);
`endif

  assign f_gnt = f_win;
  assign d_gnt = d_req && !f_win;

  assign bus.o_f_gnt = f_gnt;
  assign bus.o_d_gnt = d_gnt;

  logic [31:0] f_waddr;
  logic [32:0] f_last;
  logic        f_err;

  assign f_waddr = bus.i_f_addr & 32'hFFFF_FFFC;
  assign f_last  = {1'b0, f_waddr} + 33'd3;
  assign f_err   = (f_last >= MEM_TOP);

  logic [2:0]  d_fmt;
  logic [2:0]  d_bytes;
  logic [32:0] d_last;
  logic        d_mis, d_ill, d_err;

  assign d_fmt   = bus.i_d_fmt;
  assign d_bytes = fmt_bytes(d_fmt);
  // 33-bit sum so a 32-bit wrap lands out of range
  assign d_last  = {1'b0, bus.i_d_addr}
                 + {30'd0, d_bytes} - 33'd1;

  assign d_mis =
    ((d_fmt == FMT_H || d_fmt == FMT_HU)
      && bus.i_d_addr[0]) ||
    (d_fmt == FMT_W && bus.i_d_addr[1:0] != 2'b00);

  assign d_ill = !fmt_legal(d_fmt) ||
    (bus.i_d_we &&
      (d_fmt == FMT_BU || d_fmt == FMT_HU));

  assign d_err = d_mis || d_ill || (d_last >= MEM_TOP);

  // Memory mux; erroring grants keep r_en/w_en low
  always_comb begin
    bus.o_m_addr   = '0;
    bus.o_m_w_data = '0;
    bus.o_m_fmt    = '0;
    bus.o_m_r_en   = 1'b0;
    bus.o_m_w_en   = 1'b0;
    unique case (1'b1)
      f_gnt: begin
        bus.o_m_addr = f_waddr;
        bus.o_m_fmt  = FMT_W;
        bus.o_m_r_en = !f_err;
      end
      d_gnt: begin
        bus.o_m_addr   = bus.i_d_addr;
        bus.o_m_w_data = bus.i_d_w_data;
        bus.o_m_fmt    = d_fmt;
        bus.o_m_r_en   = !bus.i_d_we && !d_err;
        bus.o_m_w_en   = bus.i_d_we && !d_err;
      end
      default: ;
    endcase
  end

  rsp_state_t  rsp_q, rsp_d;
  logic [31:0] f_inst_q, f_inst_d;
  logic        f_err_q, f_err_d;
  logic [31:0] d_data_q, d_data_d;
  logic        d_err_q, d_err_d;

  always_comb begin
    rsp_d    = RSP_IDLE;
    f_inst_d = '0;
    f_err_d  = 1'b0;
    d_data_d = '0;
    d_err_d  = 1'b0;
    unique case (1'b1)
      f_gnt: begin
        rsp_d    = RSP_F;
        f_err_d  = f_err;
        f_inst_d = f_err ? '0 : bus.i_m_r_data;
      end
      d_gnt: begin
        rsp_d    = RSP_D;
        d_err_d  = d_err;
        d_data_d = (bus.i_d_we || d_err)
                 ? '0 : bus.i_m_r_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_q    <= RSP_IDLE;
      f_inst_q <= '0;
      f_err_q  <= 1'b0;
      d_data_q <= '0;
      d_err_q  <= 1'b0;
    end else begin
      rsp_q    <= rsp_d;
      f_inst_q <= f_inst_d;
      f_err_q  <= f_err_d;
      d_data_q <= d_data_d;
      d_err_q  <= d_err_d;
    end
  end

  assign bus.o_f_rvalid = (rsp_q == RSP_F);
  assign bus.o_f_inst   = f_inst_q;
  assign bus.o_f_err    = f_err_q;
  assign bus.o_d_rvalid = (rsp_q == RSP_D);
  assign bus.o_d_r_data = d_data_q;
  assign bus.o_d_err    = d_err_q;

endmodule
